// File: rtl/la_capture_buffer.sv
// Logic-analyser capture engine: circular sample RAM with pre-trigger history, post-trigger count,
// oldest-first readback and STATUS snapshot. Define LA_TRIG_MASK_EN to add a data-pattern trigger.
module la_capture_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              CAP_EN,
  input  logic              ARM,
  input  logic              TRIG,
  input  logic [ADDR_W-1:0] POST_CNT,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] DOUT,
  input  logic              STS_CE,
  output logic [ADDR_W+2:0] STATUS,
`ifdef LA_TRIG_MASK_EN
  input  logic [DATA_W-1:0] TRIG_MASK,
  input  logic [DATA_W-1:0] TRIG_VAL,
`endif
  output logic              BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] trig_ptr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic              wrapped_q;
  logic              triggered_q;
  logic [DATA_W-1:0] dout_p1;
  logic [ADDR_W+2:0] status_q;

  logic              capturing;
  logic              wr_en;
  logic              trig_in;
  logic              trig_hit;
  logic              done;
  logic [ADDR_W-1:0] rd_phys_p0;

`ifdef LA_TRIG_MASK_EN
  function automatic logic pattern_hit(input logic [DATA_W-1:0] din,
                                       input logic [DATA_W-1:0] mask,
                                       input logic [DATA_W-1:0] val);
    pattern_hit = (((din ^ val) & mask) == '0) && (mask != '0);
  endfunction

  assign trig_in = TRIG | pattern_hit(DIN, TRIG_MASK, TRIG_VAL);
`else
  assign trig_in = TRIG;
`endif

  // ARM and RESET both suppress the same-cycle sample write
  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
  assign wr_en     = CAP_EN && capturing && !ARM && !RESET;
  assign trig_hit  = wr_en && (state_q == S_ARMED) && trig_in;
  assign done      = (state_q == S_DONE);
  assign BUSY      = capturing;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ARM) begin
      state_d = S_ARMED;
    end else if (wr_en) begin
      if (trig_hit) begin
        state_d = (POST_CNT == '0) ? S_DONE : S_POST;
      end else if ((state_q == S_POST) && (remaining_q == ADDR_W'(1))) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q      <= '0;
      trig_ptr_q  <= '0;
      remaining_q <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else if (ARM) begin
      wptr_q      <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else if (wr_en) begin
      wptr_q <= wptr_q + ADDR_W'(1);
      if (wptr_q == '1) wrapped_q <= 1'b1;
      if (trig_hit) begin
        trig_ptr_q  <= wptr_q;
        triggered_q <= 1'b1;
        remaining_q <= POST_CNT;
      end else if (state_q == S_POST) begin
        remaining_q <= remaining_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) ram[wptr_q] <= DIN;
  end

  // Read stage: once wrapped, the oldest sample sits at the write pointer
  assign rd_phys_p0 = wrapped_q ? (wptr_q + RD_ADDR) : RD_ADDR;

  always_ff @(posedge CLK) begin
    if (RESET) dout_p1 <= '0;
    else       dout_p1 <= ram[rd_phys_p0];
  end

  assign DOUT = dout_p1;

  always_ff @(posedge CLK) begin
    if (RESET)       status_q <= '0;
    else if (STS_CE) status_q <= {done, wrapped_q, triggered_q, wptr_q};
  end

  assign STATUS = status_q;

endmodule
